mem_demux: RTL and testbench

MEM_DEMUX -- requirements
Module: mem_demux

---
 rtl/mem_demux_if.sv | 35 +++
 rtl/mem_demux.sv | 122 ++++++++++++
 tb/tb_mem_demux.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_demux_if.sv
// Bundles the upstream request port, the two target ports and the read response for mem_demux.
interface mem_demux_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [31:0] out_addr;
    logic [31:0] out_wdata;
    logic        out_we;
    logic        a_valid;
    logic        a_ready;
    logic        b_valid;
    logic        b_ready;
    logic        a_rvalid;
    logic [31:0] a_rdata;
    logic        b_rvalid;
    logic [31:0] b_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we,
        input  a_ready, b_ready, a_rvalid, a_rdata, b_rvalid, b_rdata,
        output req_ready, out_addr, out_wdata, out_we,
        output a_valid, b_valid, rsp_valid, rsp_rdata
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we,
        output a_ready, b_ready, a_rvalid, a_rdata, b_rvalid, b_rdata,
        input  req_ready, out_addr, out_wdata, out_we,
        input  a_valid, b_valid, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_demux.sv
// Single-outstanding request demultiplexer: routes one captured request to target A or B
// by address decode and returns the selected target's read data as a one-cycle response.
module mem_demux #(
    parameter logic [31:0] B_BASE = 32'h1000_0000,
    parameter logic [31:0] B_MASK = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,
    mem_demux_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    function automatic logic addr_is_b(input logic [31:0] addr);
        return (addr & B_MASK) == B_BASE;
    endfunction

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        a_valid_q, a_valid_d;
    logic        b_valid_q, b_valid_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        tgt_ready_s;
    logic        tgt_rvalid_s;
    logic [31:0] tgt_rdata_s;

    assign tgt_ready_s  = sel_q ? bus.b_ready  : bus.a_ready;
    assign tgt_rvalid_s = sel_q ? bus.b_rvalid : bus.a_rvalid;
    assign tgt_rdata_s  = sel_q ? bus.b_rdata  : bus.a_rdata;

    // Next-state and next-output logic; every output is re-registered from the next state.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    we_d    = bus.req_we;
                    sel_d   = addr_is_b(bus.req_addr);
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (tgt_ready_s) begin
                    state_d = we_q ? IDLE : WAIT;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                if (tgt_rvalid_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = tgt_rdata_s;
                    state_d     = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        a_valid_d   = (state_d == ISSUE) && !sel_d;
        b_valid_d   = (state_d == ISSUE) &&  sel_d;
        req_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            we_q        <= 1'b0;
            a_valid_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            a_valid_q   <= a_valid_d;
            b_valid_q   <= b_valid_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_wdata = wdata_q;
    assign bus.out_we    = we_q;
    assign bus.a_valid   = a_valid_q;
    assign bus.b_valid   = b_valid_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_demux.sv
// Directed bench for mem_demux: a vector table of single transactions plus hand-written
// sequences for cross-talk, upstream backpressure and mid-transaction reset.
module tb_mem_demux;

    logic clk;
    logic rst;
    mem_demux_if bus();

    mem_demux dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        int          ready_wait;
        int          rvalid_wait;
        logic [31:0] rdata;
        logic        exp_b;
    } vec_t;

    vec_t vecs[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_we    = 1'b0;
        bus.a_ready   = 1'b0;
        bus.b_ready   = 1'b0;
        bus.a_rvalid  = 1'b0;
        bus.a_rdata   = 32'h0;
        bus.b_rvalid  = 1'b0;
        bus.b_rdata   = 32'h0;
    endtask

    task automatic set_sel_ready(input logic b, input logic val);
        if (b) bus.b_ready = val;
        else   bus.a_ready = val;
    endtask

    task automatic run_txn(input vec_t v);
        chk1({v.name, " req_ready idle"}, bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.req_we    = v.we;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h0;
        // Non-selected target asserts ready and rvalid throughout; both must be ignored.
        if (v.exp_b) begin
            bus.a_ready = 1'b1; bus.a_rvalid = 1'b1; bus.a_rdata = 32'hBAD0_BAD0;
        end else begin
            bus.b_ready = 1'b1; bus.b_rvalid = 1'b1; bus.b_rdata = 32'hBAD0_BAD0;
        end
        chk({v.name, " out_addr"}, bus.out_addr, v.addr);
        chk({v.name, " out_wdata"}, bus.out_wdata, v.wdata);
        chk1({v.name, " out_we"}, bus.out_we, v.we);
        chk1({v.name, " a_valid issue"}, bus.a_valid, !v.exp_b);
        chk1({v.name, " b_valid issue"}, bus.b_valid, v.exp_b);
        chk1({v.name, " req_ready issue"}, bus.req_ready, 1'b0);
        for (int k = 0; k < v.ready_wait; k++) begin
            @(negedge clk);
            chk1({v.name, " valid held"}, v.exp_b ? bus.b_valid : bus.a_valid, 1'b1);
            chk({v.name, " out_wdata stable"}, bus.out_wdata, v.wdata);
        end
        set_sel_ready(v.exp_b, 1'b1);
        @(negedge clk);
        set_sel_ready(v.exp_b, 1'b0);
        chk1({v.name, " a_valid after hs"}, bus.a_valid, 1'b0);
        chk1({v.name, " b_valid after hs"}, bus.b_valid, 1'b0);
        chk1({v.name, " rsp_valid after hs"}, bus.rsp_valid, 1'b0);
        if (v.we) begin
            chk1({v.name, " req_ready after write"}, bus.req_ready, 1'b1);
        end else begin
            chk1({v.name, " req_ready wait"}, bus.req_ready, 1'b0);
            for (int k = 0; k < v.rvalid_wait; k++) begin
                @(negedge clk);
                chk1({v.name, " rsp_valid early"}, bus.rsp_valid, 1'b0);
                chk({v.name, " out_addr wait"}, bus.out_addr, v.addr);
            end
            if (v.exp_b) begin bus.b_rvalid = 1'b1; bus.b_rdata = v.rdata; end
            else         begin bus.a_rvalid = 1'b1; bus.a_rdata = v.rdata; end
            @(negedge clk);
            if (v.exp_b) bus.b_rvalid = 1'b0;
            else         bus.a_rvalid = 1'b0;
            chk1({v.name, " rsp_valid"}, bus.rsp_valid, 1'b1);
            chk({v.name, " rsp_rdata"}, bus.rsp_rdata, v.rdata);
            chk1({v.name, " req_ready with rsp"}, bus.req_ready, 1'b1);
            @(negedge clk);
            chk1({v.name, " rsp_valid one cycle"}, bus.rsp_valid, 1'b0);
            chk({v.name, " rsp_rdata hold"}, bus.rsp_rdata, v.rdata);
        end
        clear_inputs();
    endtask

    initial begin
        vecs[0] = '{"rd_a_40",    32'h0000_0040, 32'h0,          1'b0, 0, 0, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{"wr_b_4",     32'h1000_0004, 32'h0000_00A5,  1'b1, 3, 0, 32'h0,         1'b1};
        vecs[2] = '{"rd_0fff",    32'h0FFF_FFFC, 32'h0,          1'b0, 1, 2, 32'hA000_0001, 1'b0};
        vecs[3] = '{"rd_1000",    32'h1000_0000, 32'h0,          1'b0, 0, 1, 32'hB000_0002, 1'b1};
        vecs[4] = '{"rd_1fff",    32'h1FFF_FFFC, 32'h0,          1'b0, 2, 0, 32'hB000_0003, 1'b1};
        vecs[5] = '{"rd_2000",    32'h2000_0000, 32'h0,          1'b0, 0, 0, 32'hA000_0004, 1'b0};
        vecs[6] = '{"wr_a",       32'h0000_0100, 32'h1234_5678,  1'b1, 0, 0, 32'h0,         1'b0};
        vecs[7] = '{"wr_b_ffff",  32'h1FFF_FFFF, 32'h8765_4321,  1'b1, 1, 0, 32'h0,         1'b1};

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk1("rst req_ready", bus.req_ready, 1'b1);
        chk1("rst a_valid", bus.a_valid, 1'b0);
        chk1("rst b_valid", bus.b_valid, 1'b0);
        chk1("rst rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst out_addr", bus.out_addr, 32'h0);
        chk("rst out_wdata", bus.out_wdata, 32'h0);
        chk1("rst out_we", bus.out_we, 1'b0);
        chk("rst rsp_rdata", bus.rsp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Cross-talk: A read data during a B read must not produce a response.
        bus.req_valid = 1'b1; bus.req_addr = 32'h1000_0008; bus.req_we = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.b_ready = 1'b1;
        @(negedge clk);
        bus.b_ready = 1'b0; bus.a_rvalid = 1'b1; bus.a_rdata = 32'h1111_1111;
        @(negedge clk);
        bus.a_rvalid = 1'b0;
        chk1("xtalk no rsp on a_rvalid", bus.rsp_valid, 1'b0);
        chk1("xtalk still waiting", bus.req_ready, 1'b0);
        bus.b_rvalid = 1'b1; bus.b_rdata = 32'h2222_2222;
        @(negedge clk);
        bus.b_rvalid = 1'b0;
        chk1("xtalk rsp_valid", bus.rsp_valid, 1'b1);
        chk("xtalk rsp_rdata", bus.rsp_rdata, 32'h2222_2222);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("xtalk single pulse", bus.rsp_valid, 1'b0);
        end

        // Upstream backpressure: req_valid held; second request captured only from IDLE.
        bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0040; bus.req_we = 1'b0;
        @(negedge clk);
        chk1("bp req_ready issue", bus.req_ready, 1'b0);
        bus.req_addr = 32'h1000_0010; bus.a_ready = 1'b1;
        @(negedge clk);
        bus.a_ready = 1'b0;
        chk1("bp req_ready wait", bus.req_ready, 1'b0);
        chk("bp out_addr held", bus.out_addr, 32'h0000_0040);
        @(negedge clk);
        chk("bp out_addr held 2", bus.out_addr, 32'h0000_0040);
        bus.a_rvalid = 1'b1; bus.a_rdata = 32'h5555_5555;
        @(negedge clk);
        bus.a_rvalid = 1'b0;
        chk1("bp rsp_valid", bus.rsp_valid, 1'b1);
        chk("bp rsp_rdata", bus.rsp_rdata, 32'h5555_5555);
        chk1("bp req_ready with rsp", bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("bp second capture", bus.out_addr, 32'h1000_0010);
        chk1("bp second b_valid", bus.b_valid, 1'b1);
        chk1("bp rsp dropped", bus.rsp_valid, 1'b0);
        bus.b_ready = 1'b1;
        @(negedge clk);
        bus.b_ready = 1'b0; bus.b_rvalid = 1'b1; bus.b_rdata = 32'h7777_7777;
        @(negedge clk);
        bus.b_rvalid = 1'b0;
        chk("bp second rsp", bus.rsp_rdata, 32'h7777_7777);
        @(negedge clk);

        // Reset in ISSUE drops b_valid asynchronously.
        bus.req_valid = 1'b1; bus.req_addr = 32'h1000_0020; bus.req_we = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk1("rst_issue b_valid before", bus.b_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("rst_issue b_valid async", bus.b_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);

        // Reset in WAIT for A, then late a_rvalid must be ignored.
        bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0080; bus.req_we = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.a_ready = 1'b1;
        @(negedge clk);
        bus.a_ready = 1'b0;
        chk1("rst_wait in wait", bus.req_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk1("rst_wait req_ready async", bus.req_ready, 1'b1);
        chk("rst_wait out_addr async", bus.out_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.a_rvalid = 1'b1; bus.a_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.a_rvalid = 1'b0;
        chk1("rst_wait no rsp", bus.rsp_valid, 1'b0);
        chk("rst_wait rsp_rdata", bus.rsp_rdata, 32'h0);
        chk1("rst_wait req_ready", bus.req_ready, 1'b1);
        chk1("rst_wait a_valid", bus.a_valid, 1'b0);
        chk1("rst_wait out_we", bus.out_we, 1'b0);
        @(negedge clk);
        chk1("rst_wait no late rsp", bus.rsp_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
